// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the 3x3 convolution scheduler.
package conv_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        ISSUE,
        WRITE,
        DONE
    } state_t;

    localparam int TAPS  = 9;
    localparam int PIX_W = 8;
    localparam int WGT_W = 8;
    localparam int RES_W = 16;

    function automatic int lin_addr(input int y, input int x, input int w);
        return y * w + x;
    endfunction

endpackage

// File: rtl/conv_window_regs.sv
// 3x3 window tap array, row-major tap index i*3+j.
// Shift moves every row one column left; load writes one tap from the RAM.
module conv_window_regs
    import conv_sched_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    shift_en,
    input  logic                    load_en,
    input  logic [3:0]              load_idx,
    input  logic [PIX_W-1:0]        load_data,
    output logic [TAPS*PIX_W-1:0]   taps
);

    logic [PIX_W-1:0] tap_q [TAPS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int t = 0; t < TAPS; t++) tap_q[t] <= '0;
        end else if (shift_en) begin
            // column 2 is left stale; the fetch that follows overwrites it
            for (int i = 0; i < 3; i++) begin
                tap_q[i*3]     <= tap_q[i*3 + 1];
                tap_q[i*3 + 1] <= tap_q[i*3 + 2];
            end
        end else if (load_en) begin
            for (int t = 0; t < TAPS; t++) begin
                if (load_idx == 4'(t)) tap_q[t] <= load_data;
            end
        end
    end

    always_comb begin
        taps = '0;
        for (int t = 0; t < TAPS; t++) taps[t*PIX_W +: PIX_W] = tap_q[t];
    end

endmodule

// File: rtl/conv3x3_scheduler.sv
// Raster-order scheduler feeding 3x3 windows and kernel taps to the conv engine
// and writing the engine result to the output buffer.
module conv3x3_scheduler
    import conv_sched_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     k_we,
    input  logic [3:0]               k_idx,
    input  logic signed [WGT_W-1:0]  k_data,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [PIX_W-1:0]  rd_data,
    output logic                     win_valid,
    output logic signed [PIX_W-1:0]  win_00, win_01, win_02,
    output logic signed [PIX_W-1:0]  win_10, win_11, win_12,
    output logic signed [PIX_W-1:0]  win_20, win_21, win_22,
    output logic signed [WGT_W-1:0]  ker_00, ker_01, ker_02,
    output logic signed [WGT_W-1:0]  ker_10, ker_11, ker_12,
    output logic signed [WGT_W-1:0]  ker_20, ker_21, ker_22,
    input  logic signed [RES_W-1:0]  conv_res,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic signed [RES_W-1:0]  wr_data
);

    state_t                 state;
    logic [7:0]             r_cnt, c_cnt;
    logic [1:0]             fi, fj;
    logic                   row_start;
    logic                   ld_en;
    logic [3:0]             ld_tap;
    logic [WGT_W-1:0]       ker_q [TAPS];
    logic [TAPS*PIX_W-1:0]  win_taps;

    logic [3:0]             rd_tap;
    logic [1:0]             ni, nj;
    logic                   last_read, last_col, last_row, shift_en;
    logic [ADDR_W-1:0]      next_rd_addr, row_first_addr, step_addr;

    // Row starts walk 3 rows per column; interior steps only walk column 2.
    always_comb begin
        rd_tap    = ({2'b00, fi} * 4'd3) + {2'b00, fj};
        last_read = row_start ? (fi == 2'd2 && fj == 2'd2) : (fi == 2'd2);
        last_col  = (c_cnt == 8'(IMG_W - 3));
        last_row  = (r_cnt == 8'(IMG_H - 3));
        shift_en  = (state == WRITE) && !last_col;
        ni = fi + 2'd1;
        nj = fj;
        if (row_start && fi == 2'd2) begin
            ni = 2'd0;
            nj = fj + 2'd1;
        end
        next_rd_addr   = ADDR_W'(lin_addr(int'(r_cnt) + int'(ni), int'(c_cnt) + int'(nj), IMG_W));
        row_first_addr = ADDR_W'(lin_addr(int'(r_cnt) + 1, 0, IMG_W));
        step_addr      = ADDR_W'(lin_addr(int'(r_cnt), int'(c_cnt) + 3, IMG_W));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            win_valid <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            r_cnt     <= '0;
            c_cnt     <= '0;
            fi        <= '0;
            fj        <= '0;
            row_start <= 1'b0;
            ld_en     <= 1'b0;
            ld_tap    <= '0;
        end else begin
            // the read issued this cycle returns next cycle and is loaded then
            ld_en  <= rd_en;
            ld_tap <= rd_tap;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FETCH;
                        busy      <= 1'b1;
                        rd_en     <= 1'b1;
                        rd_addr   <= '0;
                        r_cnt     <= '0;
                        c_cnt     <= '0;
                        fi        <= '0;
                        fj        <= '0;
                        row_start <= 1'b1;
                    end
                end
                FETCH: begin
                    if (last_read) begin
                        state <= DRAIN;
                        rd_en <= 1'b0;
                    end else begin
                        fi      <= ni;
                        fj      <= nj;
                        rd_addr <= next_rd_addr;
                    end
                end
                DRAIN: begin
                    state     <= ISSUE;
                    win_valid <= 1'b1;
                end
                ISSUE: begin
                    state     <= WRITE;
                    win_valid <= 1'b0;
                    wr_en     <= 1'b1;
                    wr_addr   <= ADDR_W'(lin_addr(int'(r_cnt), int'(c_cnt), IMG_W - 2));
                end
                WRITE: begin
                    wr_en <= 1'b0;
                    if (last_col && last_row) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= FETCH;
                        rd_en <= 1'b1;
                        fi    <= '0;
                        if (last_col) begin
                            c_cnt     <= '0;
                            r_cnt     <= r_cnt + 8'd1;
                            fj        <= '0;
                            row_start <= 1'b1;
                            rd_addr   <= row_first_addr;
                        end else begin
                            c_cnt     <= c_cnt + 8'd1;
                            fj        <= 2'd2;
                            row_start <= 1'b0;
                            rd_addr   <= step_addr;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int t = 0; t < TAPS; t++) ker_q[t] <= '0;
        end else begin
            for (int t = 0; t < TAPS; t++) begin
                if (k_we && !busy && k_idx == 4'(t)) ker_q[t] <= k_data;
            end
        end
    end

    conv_window_regs u_win (
        .clk       (clk),
        .reset_n   (reset_n),
        .shift_en  (shift_en),
        .load_en   (ld_en),
        .load_idx  (ld_tap),
        .load_data (rd_data),
        .taps      (win_taps)
    );

    // The engine already registers its result, so WRITE forwards it directly.
    assign wr_data = wr_en ? conv_res : '0;

    assign win_00 = win_taps[0*PIX_W +: PIX_W];
    assign win_01 = win_taps[1*PIX_W +: PIX_W];
    assign win_02 = win_taps[2*PIX_W +: PIX_W];
    assign win_10 = win_taps[3*PIX_W +: PIX_W];
    assign win_11 = win_taps[4*PIX_W +: PIX_W];
    assign win_12 = win_taps[5*PIX_W +: PIX_W];
    assign win_20 = win_taps[6*PIX_W +: PIX_W];
    assign win_21 = win_taps[7*PIX_W +: PIX_W];
    assign win_22 = win_taps[8*PIX_W +: PIX_W];

    assign ker_00 = ker_q[0];
    assign ker_01 = ker_q[1];
    assign ker_02 = ker_q[2];
    assign ker_10 = ker_q[3];
    assign ker_11 = ker_q[4];
    assign ker_12 = ker_q[5];
    assign ker_20 = ker_q[6];
    assign ker_21 = ker_q[7];
    assign ker_22 = ker_q[8];

endmodule

// File: doc/conv3x3_scheduler.md
# conv3x3_scheduler

Sequencing controller for the 3x3 convolution + ReLU engine. It walks a stored IMG_H x IMG_W signed 8-bit feature map in raster order and fetches each 3x3 window from a synchronous single-port RAM, reusing two columns on every step to the right. It holds the nine kernel weights, presents one window per output position to the engine, and writes the engine's 16-bit result to an output buffer. The block sits between the feature-map RAM, the engine and the output RAM. Software starts it with a pulse and sees a single done pulse.

## Interface
- IMG_W, 8: input width in pixels. Must be at least 3.
- IMG_H, 8: input height in pixels. Must be at least 3.
- ADDR_W, 8: width of the input and output address buses.
- clk  in  1: single clock. Rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- start  in  1: one-cycle request. Sampled only in IDLE.
- busy  out  1: high from the cycle after start is accepted through the WRITE of the last position.
- done  out  1: one-cycle pulse after the last write.
- k_we  in  1: kernel write strobe. Ignored while busy.
- k_idx  in  4: kernel tap index 0..8, row-major. Values 9..15 are ignored.
- k_data  in  8 signed: kernel weight.
- rd_en  out  1: input RAM read enable.
- rd_addr  out  ADDR_W: input RAM address.
- rd_data  in  8 signed: input RAM data, valid the cycle after rd_en.
- win_valid  out  1: one-cycle strobe to the engine.
- win_ij  out  8 signed each (9 ports, i,j = 0..2): window taps to the engine.
- ker_ij  out  8 signed each (9 ports): kernel taps to the engine.
- conv_res  in  16 signed: registered engine output, valid the cycle after win_valid.
- wr_en  out  1: output RAM write enable.
- wr_addr  out  ADDR_W: output RAM address.
- wr_data  out  16 signed: output RAM data.

## Operation
- Output map size is (IMG_H-2) x (IMG_W-2). Output position (r,c) has wr_addr = r*(IMG_W-2)+c.
- Pixel (y,x) has rd_addr = y*IMG_W+x.
- The window for (r,c) covers rows r..r+2 and columns c..c+2.
- States:
  - IDLE: leaves to FETCH on start.
  - FETCH: leaves to DRAIN after the last read is issued.
  - DRAIN: always leaves to ISSUE.
  - ISSUE: always leaves to WRITE.
  - WRITE: goes to FETCH if positions remain, otherwise to DONE.
  - DONE: always returns to IDLE.
- Row start (c=0): FETCH issues 9 reads, column-major. Column j=0..2 in order, rows i=0..2 within each column.
- Interior step (c>0): the window shifts left one column and FETCH issues 3 reads of column c+2, rows r..r+2.
- Each returning rd_data is written into its window tap on the cycle it is valid.
- ISSUE: win_valid=1. Window and kernel taps are stable during ISSUE.
- WRITE: wr_en=1 and wr_data=conv_res. The block passes conv_res through without modification; ReLU is done by the engine.
- After WRITE, c increments. At c=IMG_W-3, c wraps to 0 and r increments. After the last position the FSM goes to DONE.
- Kernel registers are loaded by k_we when not busy. They keep their value across runs and reset to 0.
- start while busy is ignored. k_we while busy is ignored and the kernel registers stay unchanged.
- Reset at any time, including mid-run, takes effect immediately:
  - FSM to IDLE.
  - All window taps, kernel taps, counters and outputs to 0.
  - No further rd_en or wr_en until the next start.

## Timing
- Reset values: busy, done, rd_en, rd_addr, win_valid, wr_en, wr_addr, wr_data, all win_ij and all ker_ij are 0.
- Position cost, with N = 9 at row start and N = 3 otherwise:
  - N FETCH cycles.
  - 1 DRAIN cycle.
  - 1 ISSUE cycle.
  - 1 WRITE cycle.
- Run length = (IMG_H-2) x (12 + (IMG_W-3) x 6) cycles. This is 252 cycles for the 8x8 default.
- done is high exactly one cycle later than the last WRITE.
- busy falls when DONE is entered.
- rd_en is high only in FETCH.
- A new start is accepted in the cycle after DONE.

## Structure
- Shared package conv_sched_pkg contains:
  - the state enum: IDLE, FETCH, DRAIN, ISSUE, WRITE, DONE;
  - the constant TAPS = 9;
  - the pixel, weight and result width constants (8, 8, 16).
- Sub-module conv_window_regs holds the 3x3 tap array. It has a shift-left enable and a per-tap load for incoming rd_data.

## Test plan
- Basic run: IMG_W=IMG_H=4, RAM[a]=a, all nine weights 1, start, and the bench engine returns the plain sum. Required: exactly 4 writes, addresses 0,1,2,3, data 45,54,81,90.
- Cycle count: same setup as the basic run, start sampled at edge e0. Required:
  - busy rises in cycle 1;
  - writes occur in cycles 12, 18, 30 and 36;
  - done is high only in cycle 37.
- Read ordering: 8x8 run. Required:
  - rd_addr for position (0,0) is 0,8,16,1,9,17,2,10,18;
  - position (0,1) reads only 3,11,19;
  - position (1,0) reads 9 addresses starting at 8.
- ReLU and sign path: all weights -1 and an engine model with ReLU. Required: every wr_data = 0. With weight 127 and pixel -128 at the centre tap only, ker_11 and win_11 carry 127 and -128 unchanged.
- Protection: k_we with k_idx=4 and k_data=5 during busy. Required: ker_11 is unchanged. A second start during busy gives no restart and the write count is unchanged.
- Reset mid-run: drop reset_n during the third FETCH cycle. Required:
  - all outputs are 0 immediately;
  - no rd_en or wr_en before the next start;
  - a new run from start reproduces the basic-run results.
